// File: rtl/blockade_cen_pkg.sv
// ----------------------------------------------------------------------------
// blockade_cen_pkg
//   Shared types and constants for the multi-channel fractional clock-enable
//   generator (blockade_cen_gen and its per-channel NCO).
//   - cen_state_t : lock sequencer states
//   - defaults for accumulator width and lock delay, channel limit
//   - chan_slice  : pulls one channel's field out of a packed config bus
// ----------------------------------------------------------------------------
package blockade_cen_pkg;

    typedef enum logic {
        CEN_SETTLE = 1'b0,
        CEN_LOCKED = 1'b1
    } cen_state_t;

    localparam int ACC_W_DEF      = 16;
    localparam int LOCK_DELAY_DEF = 16;
    localparam int CHANNELS_MAX   = 8;
    localparam int ACC_W_MAX      = 32;
    localparam int BUS_W_MAX      = CHANNELS_MAX * ACC_W_MAX;

    // Returns field 'ch' of width 'w' from a bus packed as [ch*w +: w],
    // zero-extended to ACC_W_MAX bits. Callers cast down to their width.
    function automatic logic [ACC_W_MAX-1:0] chan_slice(
        input logic [BUS_W_MAX-1:0] bus,
        input int                   ch,
        input int                   w
    );
        logic [BUS_W_MAX-1:0] shifted;
        logic [ACC_W_MAX-1:0] mask;
        shifted = bus >> (ch * w);
        mask    = (w >= ACC_W_MAX) ? '1 : ((ACC_W_MAX'(1) << w) - ACC_W_MAX'(1));
        return shifted[ACC_W_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/blockade_cen_nco.sv
// ----------------------------------------------------------------------------
// blockade_cen_nco
//   One fractional enable channel: captures NUM/DEN on load, and while 'run'
//   is high steps a modulo-DEN accumulator by NUM, pulsing cen each time it
//   crosses DEN. Produces NUM pulses per DEN run cycles, exactly.
//   Optional macro BLOCKADE_CEN_PHASE_EN adds cfg_phase, used as the
//   accumulator reload value (reduced into [0, DEN-1]); otherwise reload is 0.
// Ports
//   refclk    in   clock
//   rst       in   synchronous active-high reset
//   load      in   capture cfg_* and reload the accumulator
//   run       in   advance the accumulator this edge
//   cfg_num   in   numerator
//   cfg_den   in   denominator (0 disables the channel)
//   cfg_phase in   initial accumulator (BLOCKADE_CEN_PHASE_EN only)
//   cen       out  registered enable pulse
//   cfg_err   out  registered NUM>DEN flag
// ----------------------------------------------------------------------------
module blockade_cen_nco #(
    parameter int ACC_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
`ifdef BLOCKADE_CEN_PHASE_EN
    input  logic [ACC_W-1:0] cfg_phase,
`endif
    output logic             cen,
    output logic             cfg_err
);

    logic [ACC_W-1:0] num_q;
    logic [ACC_W-1:0] den_q;
    logic [ACC_W-1:0] acc_q;
    logic             cen_q;
    logic             err_q;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] reload;

`ifdef BLOCKADE_CEN_PHASE_EN
    // Single subtraction brings phases in [DEN, 2*DEN) into range; anything
    // larger is clamped to DEN-1.
    function automatic logic [ACC_W-1:0] reduce_phase(
        input logic [ACC_W-1:0] p,
        input logic [ACC_W-1:0] d
    );
        logic [ACC_W-1:0] r;
        if (d == '0)
            r = '0;
        else if (p < d)
            r = p;
        else if ((p - d) < d)
            r = p - d;
        else
            r = d - ACC_W'(1);
        return r;
    endfunction

    // An invalid config pins the accumulator at zero regardless of phase.
    assign reload = (cfg_num > cfg_den) ? '0 : reduce_phase(cfg_phase, cfg_den);
`else
    assign reload = '0;
`endif

    // One extra bit so acc+NUM never wraps.
    assign sum = {1'b0, acc_q} + {1'b0, num_q};

    always_ff @(posedge refclk) begin
        if (rst) begin
            num_q <= '0;
            den_q <= '0;
            acc_q <= '0;
            cen_q <= 1'b0;
            err_q <= 1'b0;
        end else if (load) begin
            num_q <= cfg_num;
            den_q <= cfg_den;
            acc_q <= reload;
            cen_q <= 1'b0;
            err_q <= (cfg_num > cfg_den);
        end else if (run) begin
            if (den_q == '0) begin
                cen_q <= 1'b0;
            end else if (err_q) begin
                acc_q <= '0;
                cen_q <= 1'b1;
            end else if (sum >= {1'b0, den_q}) begin
                acc_q <= ACC_W'(sum - {1'b0, den_q});
                cen_q <= 1'b1;
            end else begin
                acc_q <= sum[ACC_W-1:0];
                cen_q <= 1'b0;
            end
        end else begin
            cen_q <= 1'b0;
        end
    end

    assign cen     = cen_q;
    assign cfg_err = err_q;

endmodule

// File: rtl/blockade_cen_gen.sv
// ----------------------------------------------------------------------------
// blockade_cen_gen
//   Multi-channel fractional clock-enable generator. Each of CHANNELS outputs
//   pulses at refclk*NUM/DEN. A shared sequencer holds all channels idle for
//   LOCK_DELAY cycles after reset or cfg_load, then asserts 'locked' on the
//   same edge as the first possible enable pulse.
//   Optional macro BLOCKADE_CEN_PHASE_EN adds the cfg_phase port for
//   per-channel initial accumulator values.
// Ports
//   refclk    in   system clock (only clock)
//   rst       in   synchronous active-high reset, wins over cfg_load
//   cfg_load  in   capture cfg_num/cfg_den(/cfg_phase), restart lock sequence
//   cfg_num   in   CHANNELS*ACC_W packed numerators, ch i at [i*ACC_W +: ACC_W]
//   cfg_den   in   CHANNELS*ACC_W packed denominators
//   cfg_phase in   CHANNELS*ACC_W packed phases (BLOCKADE_CEN_PHASE_EN only)
//   cen       out  CHANNELS registered single-cycle enables
//   cfg_err   out  CHANNELS registered NUM>DEN flags
//   locked    out  enables valid
// ----------------------------------------------------------------------------
module blockade_cen_gen
    import blockade_cen_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int LOCK_DELAY = LOCK_DELAY_DEF
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      cfg_load,
    input  logic [CHANNELS*ACC_W-1:0] cfg_num,
    input  logic [CHANNELS*ACC_W-1:0] cfg_den,
`ifdef BLOCKADE_CEN_PHASE_EN
    input  logic [CHANNELS*ACC_W-1:0] cfg_phase,
`endif
    output logic [CHANNELS-1:0]       cen,
    output logic [CHANNELS-1:0]       cfg_err,
    output logic                      locked
);

    localparam int CTR_W = $clog2(LOCK_DELAY + 1);

    if (CHANNELS < 1 || CHANNELS > CHANNELS_MAX || ACC_W > ACC_W_MAX || LOCK_DELAY < 1) begin : g_bad_param
        $error("blockade_cen_gen: parameter out of range");
    end

    cen_state_t       state, state_next;
    logic [CTR_W-1:0] lock_ctr, ctr_next;
    logic             run;

    logic [BUS_W_MAX-1:0] num_bus;
    logic [BUS_W_MAX-1:0] den_bus;
`ifdef BLOCKADE_CEN_PHASE_EN
    logic [BUS_W_MAX-1:0] phase_bus;
`endif

    always_comb begin
        num_bus = '0;
        den_bus = '0;
        num_bus[CHANNELS*ACC_W-1:0] = cfg_num;
        den_bus[CHANNELS*ACC_W-1:0] = cfg_den;
`ifdef BLOCKADE_CEN_PHASE_EN
        phase_bus = '0;
        phase_bus[CHANNELS*ACC_W-1:0] = cfg_phase;
`endif
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= CEN_SETTLE;
            lock_ctr <= '0;
        end else begin
            state    <= state_next;
            lock_ctr <= ctr_next;
        end
    end

    always_comb begin
        state_next = state;
        ctr_next   = lock_ctr;
        if (cfg_load) begin
            state_next = CEN_SETTLE;
            ctr_next   = '0;
        end else begin
            case (state)
                CEN_SETTLE: begin
                    if (lock_ctr == CTR_W'(LOCK_DELAY - 1)) begin
                        state_next = CEN_LOCKED;
                        ctr_next   = '0;
                    end else begin
                        ctr_next = lock_ctr + CTR_W'(1);
                    end
                end
                CEN_LOCKED: ;
                default: state_next = CEN_SETTLE;
            endcase
        end
    end

    // Channels step on the edge that enters LOCKED, so locked and the first
    // possible pulse appear together.
    always_comb begin
        locked = (state == CEN_LOCKED);
        run    = (state_next == CEN_LOCKED);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ACC_W-1:0] ch_num;
        logic [ACC_W-1:0] ch_den;
        assign ch_num = ACC_W'(chan_slice(num_bus, i, ACC_W));
        assign ch_den = ACC_W'(chan_slice(den_bus, i, ACC_W));
`ifdef BLOCKADE_CEN_PHASE_EN
        logic [ACC_W-1:0] ch_phase;
        assign ch_phase = ACC_W'(chan_slice(phase_bus, i, ACC_W));
`endif

        blockade_cen_nco #(
            .ACC_W(ACC_W)
        ) u_nco (
            .refclk   (refclk),
            .rst      (rst),
            .load     (cfg_load),
            .run      (run),
            .cfg_num  (ch_num),
            .cfg_den  (ch_den),
`ifdef BLOCKADE_CEN_PHASE_EN
            .cfg_phase(ch_phase),
`endif
            .cen      (cen[i]),
            .cfg_err  (cfg_err[i])
        );
    end

endmodule

// File: tb/tb_blockade_cen_gen.sv
// ----------------------------------------------------------------------------
// tb_blockade_cen_gen
//   Directed bench for blockade_cen_gen (CHANNELS=2, ACC_W=16, LOCK_DELAY=16).
//   A reference model predicts cen/cfg_err/locked from cycles-since-load and
//   the closed form floor((r+k*NUM)/DEN); one process compares every cycle.
//   Hand-computed expectations pin lock timing, pulse counts and gaps.
// ----------------------------------------------------------------------------
module tb_blockade_cen_gen;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int LD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic [CH*W-1:0] cfg_num;
    logic [CH*W-1:0] cfg_den;
`ifdef BLOCKADE_CEN_PHASE_EN
    logic [CH*W-1:0] cfg_phase;
`endif
    logic [CH-1:0] cen;
    logic [CH-1:0] cfg_err;
    logic          locked;

    always #5 clk = ~clk;

    blockade_cen_gen #(
        .CHANNELS  (CH),
        .ACC_W     (W),
        .LOCK_DELAY(LD)
    ) dut (
        .refclk   (clk),
        .rst      (rst),
        .cfg_load (cfg_load),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
`ifdef BLOCKADE_CEN_PHASE_EN
        .cfg_phase(cfg_phase),
`endif
        .cen      (cen),
        .cfg_err  (cfg_err),
        .locked   (locked)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           mc;
    bit           m_valid = 1'b0;
    longint       m_num[CH];
    longint       m_den[CH];
    longint       m_r[CH];
    logic [CH-1:0] exp_cen;
    logic [CH-1:0] exp_err;
    logic          exp_locked;

    function automatic logic model_pulse(input longint r, input longint n, input longint d, input longint k);
        if (d == 0) return 1'b0;
        if (n > d)  return 1'b1;
        return ((r + k * n) / d) != ((r + (k - 1) * n) / d);
    endfunction

    function automatic longint model_reload(input longint p, input longint d);
        if (d == 0)   return 0;
        if (p < d)    return p;
        if (p < 2*d)  return p - d;
        return d - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mc = 0;
            for (int i = 0; i < CH; i++) begin
                m_num[i] = 0; m_den[i] = 0; m_r[i] = 0;
            end
            exp_cen = '0;
            exp_err = '0;
            m_valid = 1'b1;
        end else if (cfg_load) begin
            mc = 0;
            for (int i = 0; i < CH; i++) begin
                m_num[i] = longint'(cfg_num[i*W +: W]);
                m_den[i] = longint'(cfg_den[i*W +: W]);
`ifdef BLOCKADE_CEN_PHASE_EN
                m_r[i] = model_reload(longint'(cfg_phase[i*W +: W]), m_den[i]);
`else
                m_r[i] = 0;
`endif
                exp_err[i] = (m_num[i] > m_den[i]);
            end
            exp_cen = '0;
        end else if (m_valid) begin
            mc++;
            for (int i = 0; i < CH; i++)
                exp_cen[i] = (mc >= LD) ? model_pulse(m_r[i], m_num[i], m_den[i], longint'(mc - LD + 1)) : 1'b0;
        end
        exp_locked = (mc >= LD);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cen_model",    32'(cen),     32'(exp_cen));
            check("err_model",    32'(cfg_err), 32'(exp_err));
            check("locked_model", 32'(locked),  32'(exp_locked));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [W-1:0] n0, input logic [W-1:0] d0,
                            input logic [W-1:0] n1, input logic [W-1:0] d1);
        cfg_num  = {n1, n0};
        cfg_den  = {d1, d0};
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic sample_run(input int n, output int c0, output int c1, output int f0, output int f1,
                              output int mn0, output int mx0, output int mn1, output int mx1);
        int l0, l1;
        c0 = 0; c1 = 0; f0 = -1; f1 = -1;
        mn0 = 1000; mx0 = 0; mn1 = 1000; mx1 = 0; l0 = -1; l1 = -1;
        for (int t = 0; t < n; t++) begin
            if (t > 0) step();
            if (cen[0]) begin
                if (l0 >= 0) begin
                    if (t - l0 < mn0) mn0 = t - l0;
                    if (t - l0 > mx0) mx0 = t - l0;
                end else f0 = t;
                l0 = t; c0++;
            end
            if (cen[1]) begin
                if (l1 >= 0) begin
                    if (t - l1 < mn1) mn1 = t - l1;
                    if (t - l1 > mx1) mx1 = t - l1;
                end else f1 = t;
                l1 = t; c1++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, f0, f1, mn0, mx0, mn1, mx1;
        logic [3:0] seq;

        rst = 1'b1; cfg_load = 1'b0; cfg_num = '0; cfg_den = '0;
`ifdef BLOCKADE_CEN_PHASE_EN
        cfg_phase = '0;
`endif
        step(); step();
        check("rst_cen",    32'(cen),     32'h0);
        check("rst_err",    32'(cfg_err), 32'h0);
        check("rst_locked", 32'(locked),  32'h0);
        rst = 1'b0;

        // 59/200 and 1/4 simultaneously
        load_cfg(16'd59, 16'd200, 16'd1, 16'd4);
        check("load_locked_low", 32'(locked), 32'h0);
        repeat (LD - 1) step();
        check("locked_before_16", 32'(locked), 32'h0);
        step();
        check("locked_at_16", 32'(locked), 32'h1);
        sample_run(200, c0, c1, f0, f1, mn0, mx0, mn1, mx1);
        check("ch0_count_200", 32'(c0),  32'd59);
        check("ch1_count_200", 32'(c1),  32'd50);
        check("ch0_min_gap",   32'(mn0), 32'd3);
        check("ch0_max_gap",   32'(mx0), 32'd4);
        check("ch1_min_gap",   32'(mn1), 32'd4);
        check("ch1_max_gap",   32'(mx1), 32'd4);

        // mid-stream reload with 1/2 on ch0
        load_cfg(16'd1, 16'd2, 16'd1, 16'd4);
        check("reload_locked_low", 32'(locked), 32'h0);
        check("reload_cen_low",    32'(cen),    32'h0);
        repeat (LD) step();
        for (int t = 0; t < 4; t++) begin
            if (t > 0) step();
            seq[t] = cen[0];
        end
        check("half_rate_seq", 32'(seq), 32'hA);

        // DEN=0 on ch0, NUM=DEN=7 on ch1
        load_cfg(16'd5, 16'd0, 16'd7, 16'd7);
        repeat (LD) step();
        sample_run(20, c0, c1, f0, f1, mn0, mx0, mn1, mx1);
        check("den0_no_pulse", 32'(c0), 32'd0);
        check("num_eq_den",    32'(c1), 32'd20);

        // NUM>DEN on ch0, NUM=0 on ch1
        load_cfg(16'd9, 16'd5, 16'd0, 16'd3);
        check("err_flag", 32'(cfg_err), 32'h1);
        repeat (LD) step();
        sample_run(20, c0, c1, f0, f1, mn0, mx0, mn1, mx1);
        check("err_cen_const", 32'(c0), 32'd20);
        check("num0_no_pulse", 32'(c1), 32'd0);

        // reset together with cfg_load in the middle of SETTLE
        load_cfg(16'd9, 16'd5, 16'd1, 16'd1);
        repeat (5) step();
        rst = 1'b1; cfg_load = 1'b1;
        step();
        rst = 1'b0; cfg_load = 1'b0;
        check("rstload_cen",    32'(cen),     32'h0);
        check("rstload_err",    32'(cfg_err), 32'h0);
        check("rstload_locked", 32'(locked),  32'h0);
        repeat (LD) step();
        check("rstload_relock", 32'(locked), 32'h1);
        sample_run(20, c0, c1, f0, f1, mn0, mx0, mn1, mx1);
        check("rstload_cfg_cleared", 32'(c0 + c1), 32'd0);

`ifdef BLOCKADE_CEN_PHASE_EN
        // 1/4 on both channels, phases 0 and 2
        cfg_phase = {16'd2, 16'd0};
        load_cfg(16'd1, 16'd4, 16'd1, 16'd4);
        repeat (LD) step();
        sample_run(12, c0, c1, f0, f1, mn0, mx0, mn1, mx1);
        check("phase0_first", 32'(f0), 32'd3);
        check("phase2_first", 32'(f1), 32'd1);
        // phase 9 with DEN 4 reloads to 3: pulse on first locked cycle
        cfg_phase = {16'd2, 16'd9};
        load_cfg(16'd1, 16'd4, 16'd1, 16'd4);
        repeat (LD) step();
        sample_run(8, c0, c1, f0, f1, mn0, mx0, mn1, mx1);
        check("phase9_first", 32'(f0), 32'd0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
